// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Brief    : Shared time-field limits for the HMS clock controller.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam int SEC_MAX   = 59;
    localparam int MIN_MAX   = 59;
    localparam int HOUR_MAX  = 23;
    localparam int HOUR_NOON = 12;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/clock_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : clock_prescaler
//  Brief    : Enabled terminal-count prescaler; one tick per i_freq+1 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_prescaler #(
    parameter int P_COUNT_BIT = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clr,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    output logic                   o_tick
);

    logic [P_COUNT_BIT-1:0] r_cnt;
    logic                   w_terminal;

    // >= rather than == so a terminal value lowered mid-count still ticks promptly
    assign w_terminal = (r_cnt >= i_freq);
    assign o_tick     = en & ~clr & w_terminal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_terminal) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + P_COUNT_BIT'(1);
            end
        end
    end

endmodule : clock_prescaler
`default_nettype wire

// File: rtl/clock_hms_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_hms_ctrl
//  Brief    : Prescaled H:M:S clock with load, 12/24h display and tick pulses.
//             Optional alarm comparator enabled by macro CLOCK_ALARM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_hms_ctrl
    import clock_pkg::*;
#(
    parameter int P_COUNT_BIT = 5,
    parameter int P_SEC_BIT   = 6,
    parameter int P_MIN_BIT   = 6,
    parameter int P_HOUR_BIT  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    input  logic                   i_load,
    input  logic [P_SEC_BIT-1:0]   i_load_sec,
    input  logic [P_MIN_BIT-1:0]   i_load_min,
    input  logic [P_HOUR_BIT-1:0]  i_load_hour,
    input  logic                   i_mode_12h,
    output logic [P_SEC_BIT-1:0]   sec,
    output logic [P_MIN_BIT-1:0]   min,
    output logic [P_HOUR_BIT-1:0]  hour,
    output logic [P_HOUR_BIT-1:0]  o_disp_hour,
    output logic                   o_pm,
    output logic                   o_sec_tick,
    output logic                   o_day_tick
`ifdef CLOCK_ALARM_EN
    ,
    input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
    input  logic [P_MIN_BIT-1:0]   i_alarm_min,
    input  logic                   i_alarm_arm,
    input  logic                   i_alarm_clr,
    output logic                   o_alarm
`endif
);

    localparam logic [P_SEC_BIT-1:0]  c_sec_max   = P_SEC_BIT'(SEC_MAX);
    localparam logic [P_MIN_BIT-1:0]  c_min_max   = P_MIN_BIT'(MIN_MAX);
    localparam logic [P_HOUR_BIT-1:0] c_hour_max  = P_HOUR_BIT'(HOUR_MAX);
    localparam logic [P_HOUR_BIT-1:0] c_hour_noon = P_HOUR_BIT'(HOUR_NOON);

    logic [P_SEC_BIT-1:0]  r_sec;
    logic [P_MIN_BIT-1:0]  r_min;
    logic [P_HOUR_BIT-1:0] r_hour;
    logic                  r_sec_tick;
    logic                  r_day_tick;

    logic                  w_tick;
    logic [P_SEC_BIT-1:0]  w_sec_nxt;
    logic [P_MIN_BIT-1:0]  w_min_nxt;
    logic [P_HOUR_BIT-1:0] w_hour_nxt;
    logic                  w_day_wrap;
    logic [P_SEC_BIT-1:0]  w_load_sec;
    logic [P_MIN_BIT-1:0]  w_load_min;
    logic [P_HOUR_BIT-1:0] w_load_hour;
    logic [P_HOUR_BIT-1:0] w_disp_hour;
    logic                  w_pm;

    clock_prescaler #(
        .P_COUNT_BIT (P_COUNT_BIT)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .clr    (i_load),
        .i_freq (i_freq),
        .o_tick (w_tick)
    );

    // Ripple carry through the three fields for the next second
    always_comb begin
        w_sec_nxt  = r_sec;
        w_min_nxt  = r_min;
        w_hour_nxt = r_hour;
        w_day_wrap = 1'b0;
        if (r_sec == c_sec_max) begin
            w_sec_nxt = '0;
            if (r_min == c_min_max) begin
                w_min_nxt = '0;
                if (r_hour == c_hour_max) begin
                    w_hour_nxt = '0;
                    w_day_wrap = 1'b1;
                end else begin
                    w_hour_nxt = r_hour + P_HOUR_BIT'(1);
                end
            end else begin
                w_min_nxt = r_min + P_MIN_BIT'(1);
            end
        end else begin
            w_sec_nxt = r_sec + P_SEC_BIT'(1);
        end
    end

    assign w_load_sec  = (i_load_sec  > c_sec_max)  ? '0 : i_load_sec;
    assign w_load_min  = (i_load_min  > c_min_max)  ? '0 : i_load_min;
    assign w_load_hour = (i_load_hour > c_hour_max) ? '0 : i_load_hour;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sec      <= '0;
            r_min      <= '0;
            r_hour     <= '0;
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
        end else if (i_load) begin
            r_sec      <= w_load_sec;
            r_min      <= w_load_min;
            r_hour     <= w_load_hour;
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
        end else if (w_tick) begin
            r_sec      <= w_sec_nxt;
            r_min      <= w_min_nxt;
            r_hour     <= w_hour_nxt;
            r_sec_tick <= 1'b1;
            r_day_tick <= w_day_wrap;
        end else begin
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
        end
    end

    always_comb begin
        w_disp_hour = r_hour;
        w_pm        = 1'b0;
        if (i_mode_12h) begin
            if (r_hour == '0) begin
                w_disp_hour = c_hour_noon;
            end else if (r_hour < c_hour_noon) begin
                w_disp_hour = r_hour;
            end else if (r_hour == c_hour_noon) begin
                w_disp_hour = c_hour_noon;
                w_pm        = 1'b1;
            end else begin
                w_disp_hour = r_hour - c_hour_noon;
                w_pm        = 1'b1;
            end
        end
    end

    assign sec         = r_sec;
    assign min         = r_min;
    assign hour        = r_hour;
    assign o_disp_hour = w_disp_hour;
    assign o_pm        = w_pm;
    assign o_sec_tick  = r_sec_tick;
    assign o_day_tick  = r_day_tick;

`ifdef CLOCK_ALARM_EN
    logic r_alarm;
    logic w_alarm_match;

    // Only a counting tick can arm the flag; a load onto the alarm time cannot
    assign w_alarm_match = i_alarm_arm & w_tick & ~i_load
                         & (w_hour_nxt == i_alarm_hour)
                         & (w_min_nxt  == i_alarm_min)
                         & (w_sec_nxt  == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_match) begin
            r_alarm <= 1'b1;
        end else if (i_alarm_clr || !i_alarm_arm) begin
            r_alarm <= 1'b0;
        end
    end

    assign o_alarm = r_alarm;
`endif

endmodule : clock_hms_ctrl
`default_nettype wire

// File: doc/clock_hms_ctrl.md
Name: clock_hms_ctrl

Overview:
- Parametrised successor to the free-running HMS clock: prescaled seconds/minutes/hours counter.
- Adds synchronous time load, a 12/24-hour display mode, registered tick outputs and an optional alarm comparator.
- Sits between the board clock and the display/segment driver; `sec`/`min`/`hour` stay 24-hour binary for downstream logic.

Parameters:
- P_COUNT_BIT, 5, width of prescaler counter and `i_freq`.
- P_SEC_BIT, 6, width of seconds field (holds 0..59).
- P_MIN_BIT, 6, width of minutes field (holds 0..59).
- P_HOUR_BIT, 5, width of hours field (holds 0..23).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (assert 0 clears all state).
- en  in  1  count enable; low freezes prescaler and time.
- i_freq  in  P_COUNT_BIT  prescale terminal value; one second = i_freq+1 enabled clk cycles.
- i_load  in  1  one-cycle request to load time.
- i_load_sec  in  P_SEC_BIT  load value for seconds.
- i_load_min  in  P_MIN_BIT  load value for minutes.
- i_load_hour  in  P_HOUR_BIT  load value for hours.
- i_mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- sec  out  P_SEC_BIT  seconds, 0..59.
- min  out  P_MIN_BIT  minutes, 0..59.
- hour  out  P_HOUR_BIT  hours, 0..23.
- o_disp_hour  out  P_HOUR_BIT  display hour per mode.
- o_pm  out  1  PM flag (12-hour mode only).
- o_sec_tick  out  1  one-cycle pulse, registered, on each second increment.
- o_day_tick  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.

Behaviour:
- Reset values:
  - All outputs 0, except `o_disp_hour`, which is combinational from `hour` and mode (so 12 when `i_mode_12h`=1 during reset).
  - Prescaler count `cnt` = 0.
- Prescaler:
  - When `en`=1: if `cnt` >= `i_freq`, raise internal tick and set `cnt` <= 0; otherwise `cnt` <= `cnt`+1.
  - The `>=` compare covers `i_freq` lowered mid-count: tick on the next enabled cycle.
  - `i_freq`=0: tick on every enabled cycle.
  - When `en`=0: `cnt` holds; no tick.
- Time update on tick:
  - `sec` increments.
  - At 59, `sec` wraps to 0 and `min` increments.
  - At `min`=59 with a `sec` wrap, `min` wraps to 0 and `hour` increments.
  - At 23:59:59, all fields go to 0 and `o_day_tick` pulses.
  - `o_sec_tick` pulses in the same cycle the new `sec` appears; latency from internal tick to outputs is 1 clk.
- Load:
  - `i_load`=1 takes priority over tick, independent of `en`.
  - Fields are loaded next edge; each out-of-range field (`sec`/`min` > 59, `hour` > 23) loads as 0.
  - `cnt` clears to 0; no tick pulses in the load cycle.
- Display mapping (combinational from `hour`):
  - 24-hour mode: `o_disp_hour` = `hour`, `o_pm` = 0.
  - 12-hour mode:
    - `hour` 0 -> 12, `o_pm` = 0.
    - `hour` 1..11 -> same value, `o_pm` = 0.
    - `hour` 12 -> 12, `o_pm` = 1.
    - `hour` 13..23 -> `hour`-12, `o_pm` = 1.
  - Mode change takes effect immediately and never alters `hour`.
- Reset asserted mid-count: all state clears asynchronously; counting resumes from 00:00:00 with `cnt`=0 after deassertion.

Optional Feature:
- Macro: CLOCK_ALARM_EN.
- When defined, add these ports:
  - `i_alarm_hour` (P_HOUR_BIT), `i_alarm_min` (P_MIN_BIT), `i_alarm_arm` (1), `i_alarm_clr` (1), `o_alarm` (1).
- Alarm set condition: `o_alarm` sets on the tick that makes `hour`:`min`:`sec` equal `i_alarm_hour`:`i_alarm_min`:00, only while `i_alarm_arm`=1.
  - It does not set on a load that lands on the alarm time.
- Alarm clear: `o_alarm` stays high until `i_alarm_clr`=1 or `i_alarm_arm`=0; it clears next edge.
  - If clear and match occur in the same cycle, set wins.
- Reset clears `o_alarm`.
- When undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package clock_pkg: constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, HOUR_NOON=12.
- Sub-module clock_prescaler: `clk`, `reset`, `en`, `clr`, `i_freq` -> `o_tick`, implementing the `cnt` logic above.
- The top holds the time registers, display mapping and alarm.

Test Plan:
- Reset low 100 ns, then `en`=1, `i_freq`=3 -> `o_sec_tick` every 4 clk; `sec` reads 1 after first pulse, 0 with `min`=1 after 60 pulses.
- Load 23:59:58, `i_freq`=0 -> two cycles later the time is 00:00:00; `o_day_tick` is high exactly one cycle, coincident with the wrap.
- Load `sec`=60, `min`=61, `hour`=24 -> time 00:00:00; `cnt` cleared; no tick in the load cycle.
- `i_mode_12h`=1 with `hour` 0/11/12/13/23 -> `o_disp_hour`/`o_pm` = 12/0, 11/0, 12/1, 1/1, 11/1.
- `en` dropped for 10 cycles mid-count, then reset asserted mid-count -> time and `cnt` frozen while `en` low; all outputs 0 immediately on reset, without waiting for a clk edge.
- CLOCK_ALARM_EN, alarm 07:30 armed, load 07:29:59 -> `o_alarm` rises one tick later and holds; `i_alarm_clr` pulse clears it.
